count_pwm_gen: RTL and testbench

//  Downstream consumer of the free-running 4-bit synchronous up-counter.
//  - Samples the counter value every clk and compares it against a double-buffered duty value to drive a PWM output.
//  - Flags counter wrap-around and counts completed periods.
//  - Detects a missing or skipped increment from the upstream counter.

---
 rtl/count_pwm_gen_pkg.sv | 13 +
 rtl/count_pwm_gen_if.sv | 11 +
 rtl/count_pwm_gen_duty_shadow_reg.sv | 44 ++++
 rtl/count_pwm_gen.sv | 78 +++++++
 tb/tb_count_pwm_gen.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/count_pwm_gen_pkg.sv
// Shared types and constants for the counter-driven PWM generator.
package count_pwm_gen_pkg;

    localparam int CW_DEF  = 4;
    localparam int PW_DEF  = 8;
    localparam int CNT_MAX = 2**CW_DEF - 1;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/count_pwm_gen_if.sv
// Duty-value valid/ready handshake between a duty source and the PWM block.
interface count_pwm_gen_if #(parameter int CW = 4);

    logic [CW-1:0] duty_in;
    logic          duty_valid;
    logic          duty_ready;

    modport master (output duty_in, output duty_valid, input  duty_ready);
    modport slave  (input  duty_in, input  duty_valid, output duty_ready);

endinterface

// File: rtl/count_pwm_gen_duty_shadow_reg.sv
// Double-buffered duty register: accepts a value into a shadow slot and
// promotes it to the active duty on the next apply strobe (counter wrap).
module duty_shadow_reg #(
    parameter int CW = 4,
    parameter logic [CW-1:0] DUTY_RST = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] duty_in,
    input  logic          duty_valid,
    output logic          duty_ready,
    input  logic          apply,
    output logic [CW-1:0] active_duty,
    output logic [CW-1:0] cmp_duty
);

    logic [CW-1:0] shadow;
    logic          pending;
    logic          accept;
    logic          load;

    // accept needs an empty shadow and load needs a full one, so they never collide
    assign accept     = duty_valid && !pending;
    assign load       = apply && pending;
    assign duty_ready = !pending;

    // The wrap sample itself must already see the new duty.
    assign cmp_duty = load ? shadow : active_duty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_duty <= DUTY_RST;
            shadow      <= '0;
            pending     <= 1'b0;
        end else if (load) begin
            active_duty <= shadow;
            pending     <= 1'b0;
        end else if (accept) begin
            shadow  <= duty_in;
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/count_pwm_gen.sv
// PWM generator driven by a free-running upstream counter, with wrap
// detection, completed-period counting and sticky continuity checking.
module count_pwm_gen
    import count_pwm_gen_pkg::*;
#(
    parameter int CW       = CW_DEF,
    parameter int PW       = PW_DEF,
    parameter int DUTY_RST = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] cnt_in,
    count_pwm_gen_if.slave duty,
    output logic          pwm_out,
    output logic          wrap_pulse,
    output logic [PW-1:0] period_count,
    output logic          stall_err
);

    localparam logic [CW-1:0] MAX_CNT = '1;
    localparam logic [CW-1:0] RST_DUTY = DUTY_RST[CW-1:0];

    state_t        state, state_nxt;
    logic          run;
    logic [CW-1:0] prev_cnt;
    logic          wrap;
    logic          skip;
    logic [CW-1:0] active_duty;
    logic [CW-1:0] cmp_duty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SYNC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        case (state)
            SYNC: state_nxt = RUN;
            RUN:  run       = 1'b1;
            default: state_nxt = SYNC;
        endcase
    end

    assign wrap = run && (prev_cnt == MAX_CNT) && (cnt_in == '0);
    assign skip = cnt_in != CW'(prev_cnt + CW'(1));

    duty_shadow_reg #(.CW(CW), .DUTY_RST(RST_DUTY)) u_shadow (
        .clk         (clk),
        .rst_n       (rst_n),
        .duty_in     (duty.duty_in),
        .duty_valid  (duty.duty_valid),
        .duty_ready  (duty.duty_ready),
        .apply       (wrap),
        .active_duty (active_duty),
        .cmp_duty    (cmp_duty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_cnt     <= '0;
            pwm_out      <= 1'b0;
            wrap_pulse   <= 1'b0;
            period_count <= '0;
            stall_err    <= 1'b0;
        end else begin
            prev_cnt <= cnt_in;
            if (run) begin
                pwm_out    <= cnt_in < cmp_duty;
                wrap_pulse <= wrap;
                if (wrap) period_count <= period_count + PW'(1);
                if (skip) stall_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_count_pwm_gen.sv
// Self-checking bench: queue-based behavioural model compared every cycle,
// plus directed literal expectations for the documented scenarios.
module tb_count_pwm_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cnt_in = '0;
    logic       pwm_out, wrap_pulse, stall_err;
    logic [7:0] period_count;

    count_pwm_gen_if #(.CW(4)) dif ();

    always #5 clk = ~clk;

    count_pwm_gen #(.CW(4), .PW(8), .DUTY_RST(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cnt_in       (cnt_in),
        .duty         (dif),
        .pwm_out      (pwm_out),
        .wrap_pulse   (wrap_pulse),
        .period_count (period_count),
        .stall_err    (stall_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: "started" flag, last count seen, and a queue holding
    // the one pending duty value waiting for the next wrap.
    bit m_sync, m_pwm, m_wrap, m_stall, m_ready, m_acc;
    int m_prev, m_active, m_pc;
    int q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sync = 1; m_prev = 0; m_active = 8; m_pc = 0;
            m_pwm = 0; m_wrap = 0; m_stall = 0; m_ready = 1;
            q.delete();
        end else begin
            m_acc = dif.duty_valid && m_ready;
            if (m_sync) begin
                m_prev = int'(cnt_in);
                m_sync = 0;
            end else begin
                m_wrap = (m_prev == 15) && (cnt_in == 0);
                if (m_wrap && q.size() > 0) m_active = q.pop_front();
                m_pwm = int'(cnt_in) < m_active;
                if (m_wrap) m_pc = (m_pc + 1) % 256;
                if (int'(cnt_in) != (m_prev + 1) % 16) m_stall = 1;
                m_prev = int'(cnt_in);
            end
            if (m_acc) q.push_back(int'(dif.duty_in));
            m_ready = (q.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_pwm", pwm_out, m_pwm);
            chk("m_wrap", wrap_pulse, m_wrap);
            chk("m_period", period_count, m_pc);
            chk("m_stall", stall_err, m_stall);
            chk("m_ready", dif.duty_ready, m_ready);
        end
    end

    task automatic tick(input logic [3:0] c, input logic v, input logic [3:0] d);
        cnt_in = c;
        dif.duty_valid = v;
        dif.duty_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pwm"}, pwm_out, 0);
        chk({tag, "_wrap"}, wrap_pulse, 0);
        chk({tag, "_pc"}, period_count, 0);
        chk({tag, "_stall"}, stall_err, 0);
        chk({tag, "_ready"}, dif.duty_ready, 1);
    endtask

    initial begin
        int guard;
        logic [3:0] c;
        dif.duty_valid = 0;
        dif.duty_in = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst_n = 1;

        // Reset release and free-running count, two periods
        tick(4'd0, 0, 0);
        chk("sync_pwm", pwm_out, 0);
        for (int k = 1; k <= 32; k++) begin
            c = 4'(k % 16);
            tick(c, 0, 0);
            if (c == 7) chk("t1_pwm7", pwm_out, 1);
            if (c == 8) chk("t1_pwm8", pwm_out, 0);
            if (c == 0) begin
                chk("t2_wrap", wrap_pulse, 1);
                chk("t2_pc", period_count, (k == 16) ? 1 : 2);
            end
            if (c == 1) chk("t2_wrap_1clk", wrap_pulse, 0);
        end

        // Duty 3 offered mid-period
        for (int k = 1; k <= 4; k++) tick(4'(k), 0, 0);
        tick(4'd5, 1, 4'd3);
        chk("t3_ready_drop", dif.duty_ready, 0);
        for (int k = 6; k <= 15; k++) begin
            tick(4'(k), 0, 0);
            if (k == 7) chk("t3_old_pwm7", pwm_out, 1);
            if (k == 8) chk("t3_old_pwm8", pwm_out, 0);
        end
        tick(4'd0, 0, 0);
        chk("t3_wrap_pwm0", pwm_out, 1);
        chk("t3_ready_back", dif.duty_ready, 1);
        tick(4'd1, 0, 0);
        tick(4'd2, 0, 0);
        chk("t3_new_pwm2", pwm_out, 1);
        tick(4'd3, 0, 0);
        chk("t3_new_pwm3", pwm_out, 0);

        // Duty offered on the wrap clock applies one period later
        for (int k = 4; k <= 15; k++) tick(4'(k), 0, 0);
        tick(4'd0, 1, 4'd12);
        chk("t4_accept", dif.duty_ready, 0);
        chk("t4_pwm0", pwm_out, 1);
        for (int k = 1; k <= 15; k++) begin
            tick(4'(k), 0, 0);
            if (k == 3) chk("t4_still3", pwm_out, 0);
        end
        tick(4'd0, 0, 0);
        chk("t4_ready_back", dif.duty_ready, 1);
        for (int k = 1; k <= 15; k++) begin
            tick(4'(k), 0, 0);
            if (k == 11) chk("t4_pwm11", pwm_out, 1);
            if (k == 12) chk("t4_pwm12", pwm_out, 0);
        end

        // Random duty traffic until the period counter overflows
        c = 4'd15;
        guard = 0;
        while (!(m_pc == 255 && c == 15) && guard < 6000) begin
            c = c + 4'd1;
            tick(c, ($urandom_range(0, 3) == 0), 4'($urandom));
            guard++;
        end
        chk("ovf_guard", (guard < 6000), 1);
        tick(4'd0, 0, 0);
        chk("t2_ovf_pc", period_count, 0);
        chk("t2_ovf_wrap", wrap_pulse, 1);

        // Held count sets sticky stall
        for (int k = 1; k <= 6; k++) tick(4'(k), 0, 0);
        chk("t5_no_stall", stall_err, 0);
        tick(4'd6, 0, 0);
        chk("t5_hold_stall", stall_err, 1);
        for (int k = 7; k <= 11; k++) tick(4'(k), 0, 0);
        chk("t5_sticky", stall_err, 1);

        // Async reset with a duty pending
        tick(4'd12, 1, 4'd2);
        chk("t6_pending", dif.duty_ready, 0);
        #3;
        rst_n = 0;
        #1;
        chk_reset_vals("t6_async");
        @(posedge clk);
        #1;
        rst_n = 1;
        tick(4'd0, 0, 0);
        for (int k = 1; k <= 18; k++) begin
            c = 4'(k % 16);
            tick(c, 0, 0);
            if (k == 7) chk("t6_rst_pwm7", pwm_out, 1);
            if (k == 8) chk("t6_rst_pwm8", pwm_out, 0);
            if (k == 18) chk("t6_no_shadow", pwm_out, 1);
        end
        chk("t6_stall_clr", stall_err, 0);

        // Skipped count sets stall
        for (int k = 3; k <= 6; k++) tick(4'(k), 0, 0);
        tick(4'd8, 0, 0);
        chk("t5_skip_stall", stall_err, 1);

        // Random phase with occasional count glitches
        rst_n = 0;
        #1;
        chk_reset_vals("rst2");
        rst_n = 1;
        c = 4'($urandom);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 49) == 0) c = 4'($urandom);
            else c = c + 4'd1;
            tick(c, ($urandom_range(0, 2) == 0), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
